// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: execute-stage / fetch-port connection to the PC and pipeline
// control unit.
//
// Signals
//   jump_en_i    redirect request from execute
//   jump_addr_i  redirect target from execute (low two bits dropped by pc_ctrl)
//   hold_flag_i  stall request from execute
//   bus_stall_i  stall request from the instruction fetch port
//   pc_o         current fetch address (registered)
//   flush_o      IF/ID and ID/EX load NOP at the next edge
//   hold_o       PC and IF/ID keep their value at the next edge
//   misalign_o   one-cycle pulse: accepted redirect target was not word aligned
//
// Modports
//   master  requester side (execute stage / fetch port / testbench)
//   slave   pc_ctrl side
interface pc_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        bus_stall_i;
    logic [31:0] pc_o;
    logic        flush_o;
    logic        hold_o;
    logic        misalign_o;

    modport master (
        output jump_en_i,
        output jump_addr_i,
        output hold_flag_i,
        output bus_stall_i,
        input  pc_o,
        input  flush_o,
        input  hold_o,
        input  misalign_o
    );

    modport slave (
        input  jump_en_i,
        input  jump_addr_i,
        input  hold_flag_i,
        input  bus_stall_i,
        output pc_o,
        output flush_o,
        output hold_o,
        output misalign_o
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter and pipeline control for the RV32I pipeline.
//
// Owns the fetch PC, redirects it on accepted jumps, squashes wrong-path
// instructions in IF/ID and ID/EX for FLUSH_CYCLES cycles per redirect, and
// freezes PC / IF/ID on stall requests.
//
// Parameters
//   RESET_ADDR    PC value loaded on reset
//   FLUSH_CYCLES  cycles flush_o stays high per redirect, including the
//                 redirect cycle itself (1..15)
//
// Ports
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   pc_ctrl_if slave modport (jump/hold/stall in, pc/flush/hold/misalign out)
//
// State
//   pc_q        fetch address
//   flush_cnt   remaining flush cycles after the redirect cycle; nonzero = busy
//   misalign_q  registered misalignment pulse
module pc_ctrl #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    pc_ctrl_if.slave  bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [31:0] pc_q;
    logic [3:0]  flush_cnt;
    logic        misalign_q;

    logic        busy;
    logic        jump_acc;
    logic        stall;
    logic [31:0] jump_tgt;
    logic        jump_misaligned;

    assign busy = (flush_cnt != 4'd0);

    // Jumps arriving inside the flush window come from squashed wrong-path
    // instructions and must not redirect again.
    assign jump_acc = bus.jump_en_i & ~busy & ~rst;

    // A redirect beats a stall in the same cycle: the stalled instruction is
    // on the wrong path anyway.
    assign stall = (bus.hold_flag_i | bus.bus_stall_i) & ~jump_acc & ~rst;

    assign jump_tgt        = {bus.jump_addr_i[31:2], 2'b00};
    assign jump_misaligned = |bus.jump_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            flush_cnt  <= 4'd0;
            misalign_q <= 1'b0;
        end else begin
            if (jump_acc) begin
                pc_q <= jump_tgt;
            end else if (!stall) begin
                pc_q <= pc_q + 32'd4;
            end

            // The window keeps counting through stalls so a long hold cannot
            // stretch the squash period.
            if (jump_acc) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (busy) begin
                flush_cnt <= flush_cnt - 4'd1;
            end else begin
                flush_cnt <= 4'd0;
            end

            misalign_q <= jump_acc & jump_misaligned;
        end
    end

    assign bus.pc_o       = pc_q;
    // Combinational in the redirect cycle so the wrong-path instruction
    // already in IF/ID is squashed at the very edge that redirects PC.
    assign bus.flush_o    = ~rst & (jump_acc | busy);
    // Still asserted during a flush so PC freezes while the pipe loads NOPs.
    assign bus.hold_o     = stall;
    assign bus.misalign_o = misalign_q;

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and pipeline-control unit for the RV32I pipeline; it is the consumer of the execute stage's `jump_en_o`/`jump_addr_o`/`hold_flag_o` outputs. It owns the fetch PC register and redirects it on taken branches/JAL. It squashes wrong-path instructions in IF/ID and ID/EX for a configurable window and stalls PC and front-end registers on hold requests.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: PC value loaded on reset.
- `FLUSH_CYCLES`, default 2: total cycles `flush_o` stays high per redirect, including the redirect cycle; legal range 1..15.
- Clocking: one clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `jump_en_i`  in  1  redirect request from execute.
- `jump_addr_i`  in  32  redirect target from execute.
- `hold_flag_i`  in  1  stall request from execute.
- `bus_stall_i`  in  1  stall request from the instruction fetch port (not ready).
- `pc_o`  out  32  current fetch address, registered.
- `flush_o`  out  1  IF/ID and ID/EX load NOP at the next edge.
- `hold_o`  out  1  PC and IF/ID keep their value at the next edge.
- `misalign_o`  out  1  one-cycle pulse: accepted redirect target had `[1:0] != 0`.

## Operation
- State: `pc_q` (32b), `flush_cnt` (4b), `misalign_q` (1b). `busy = (flush_cnt != 0)`.
- Accepted jump: `jump_acc = jump_en_i & ~busy & ~rst`. Jumps while `busy` are ignored; they come from squashed wrong-path instructions.
- Stall: `stall = (hold_flag_i | bus_stall_i) & ~jump_acc & ~rst`.
- PC next-state priority, highest first:
  - `rst`: `RESET_ADDR`.
  - `jump_acc`: `{jump_addr_i[31:2], 2'b00}`.
  - `stall`: hold.
  - else: `pc_q + 4`, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- Flush counter:
  - `rst`: 0.
  - `jump_acc`: `FLUSH_CYCLES-1`.
  - `busy`: decrement. It decrements even while stalled.
  - else: 0.
- Outputs:
  - `flush_o = ~rst & (jump_acc | busy)`. Combinational on `jump_en_i` in the redirect cycle; registered afterwards.
  - `hold_o = stall`.
  - `misalign_o = misalign_q`, where `misalign_q <= ~rst & jump_acc & (jump_addr_i[1:0] != 0)`.
- Flush vs hold: the flush window always overrides a hold, so IF/ID and ID/EX load NOP. `hold_o` is still asserted so that PC freezes.
- Simultaneous jump and hold: the jump wins, PC redirects, and `hold_o=0`.

## Timing
- Reset values, in the cycle after the `rst` edge: `pc_o=RESET_ADDR`, `flush_o=0`, `hold_o=0`, `misalign_o=0`.
- While `rst=1`, `flush_o` and `hold_o` are forced to 0.
- Redirect sampled at edge E (jump request in cycle N):
  - cycle N: `flush_o=1`.
  - cycles N+1..N+FLUSH_CYCLES-1: `flush_o=1`.
  - cycle N+1: `pc_o` equals the aligned target.
  - cycle N+1: `misalign_o` pulses if applicable.
- With `FLUSH_CYCLES=1`, `flush_o` is high only in cycle N and the next jump is accepted in N+1.
- Stall has zero latency: PC does not advance at the edge ending a cycle with `hold_o=1`.
- Reset mid-flush: the counter clears and `flush_o=0` from the reset cycle onward. No residual flush after reset.
- Back-to-back jumps: the second `jump_en_i` is accepted only once `busy=0`, earliest in cycle N+FLUSH_CYCLES.

## Test plan
- Reset, then 4 free-run cycles with `RESET_ADDR=32'h100` -> `pc_o` = 0x100, 0x104, 0x108, 0x10C; `flush_o=0` and `hold_o=0` throughout.
- At `pc_o=0x108`, pulse `jump_en_i=1`, `jump_addr_i=0x40` (FLUSH_CYCLES=2) -> `flush_o=1` in that cycle and the next; `pc_o`=0x40 then 0x44; then `flush_o=0`.
- Jump to 0x40 followed by `jump_en_i=1`, `jump_addr_i=0x80` in the next cycle -> second request ignored; `pc_o` = 0x40, 0x44, 0x48.
- `hold_flag_i=1` for 3 cycles at `pc_o=0x20` -> `hold_o=1`, `pc_o` stays 0x20 for 3 cycles, then 0x24. Repeat with `bus_stall_i` for the same result. Assert `hold_flag_i` together with `jump_en_i` to 0x200 -> `hold_o=0`, `pc_o`=0x200.
- Jump to 0x1002 -> `pc_o`=0x1000 and a one-cycle `misalign_o` pulse. Separately, free-run from `RESET_ADDR=32'hFFFF_FFF8` -> 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Assert `rst` in the cycle after a jump with FLUSH_CYCLES=4 -> `flush_o=0` during and after reset; `pc_o`=RESET_ADDR; a new jump is accepted immediately after reset.
